// File: rtl/dmem_pkg.sv
// Shared widths and FSM encoding for the data-cache memory controller.
package dmem_pkg;
    localparam int LINE_W  = 128;
    localparam int LADDR_W = 26;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WB_WAIT,
        RD_WAIT,
        RD_DONE
    } state_e;
endpackage

// File: rtl/mem_line_array.sv
// Single-port line store: synchronous write, combinational read.
module mem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);
    logic [LINE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/dcache_mem_ctrl.sv
// Backing-store model for the data cache: optional victim writeback,
// then a line fill, each phase taking LATENCY cycles.
module dcache_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_LINES = 4096,
    parameter int LATENCY   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reqD_mem,
    input  logic [LADDR_W-1:0] reqAddrD_mem,
    input  logic               reqD_cache_write,
    input  logic [LINE_W-1:0]  data_to_mem,
    input  logic [LADDR_W-1:0] reqAddrD_write_mem,
    input  logic               reqD_stop,
    output logic [LINE_W-1:0]  data_from_mem,
    output logic               read_ready_from_mem,
    output logic               written_data_ack
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  waddr_q, waddr_d;
    logic [IDX_W-1:0]  faddr_q, faddr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [LINE_W-1:0] mem_rdata;
    logic              ack;

    // Line index is address mod MEM_LINES; upper bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{reqAddrD_mem[LADDR_W-1:IDX_W],
                                reqAddrD_write_mem[LADDR_W-1:IDX_W]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        faddr_d = faddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        ack     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (reqD_mem) begin
                    waddr_d = reqAddrD_write_mem[IDX_W-1:0];
                    faddr_d = reqAddrD_mem[IDX_W-1:0];
                    wdata_d = data_to_mem;
                    cnt_d   = CNT_LOAD;
                    state_d = reqD_cache_write ? WB_WAIT : RD_WAIT;
                end
            end
            WB_WAIT: begin
                // A dropped request cannot cancel a writeback in flight.
                if (!reqD_stop) begin
                    if (cnt_q == '0) begin
                        mem_we  = 1'b1;
                        ack     = 1'b1;
                        cnt_d   = CNT_LOAD;
                        state_d = reqD_mem ? RD_WAIT : IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (!reqD_mem) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (!reqD_stop) begin
                    if (cnt_q == '0) begin
                        rdata_d = mem_rdata;
                        state_d = RD_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            RD_DONE: begin
                if (!reqD_mem) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            mem_we = 1'b0;
            ack    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        faddr_q <= faddr_d;
        wdata_q <= wdata_d;
    end

    assign mem_addr = (state_q == WB_WAIT) ? waddr_q : faddr_q;

    mem_line_array #(
        .DEPTH (MEM_LINES),
        .AW    (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign data_from_mem       = rdata_q;
    assign read_ready_from_mem = (state_q == RD_DONE);
    assign written_data_ack    = ack;
endmodule
